// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame and shifts it out as
// start bit, LSB-first data, optional parity, then one or two stop bits.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_r_en,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cyc_q;
   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] shift_q;
   logic             par_q;
   logic             bit_tick;

   assign bit_tick = (cyc_q == CYC_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (enable && !fifo_empty) state_d = FETCH;
         FETCH:  state_d = LOAD;
         LOAD:   state_d = START;
         START:  if (bit_tick) state_d = DATA;
         DATA:   if (bit_tick && bit_q == DATA_LAST)
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY: if (bit_tick) state_d = STOP;
         STOP:   if (bit_tick && bit_q == STOP_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters restart on every state change so each state sees a clean bit period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         if (state_d != state_q || state_q == IDLE || state_q == FETCH || state_q == LOAD) begin
            cyc_q <= '0;
            bit_q <= '0;
         end else if (bit_tick) begin
            cyc_q <= '0;
            bit_q <= bit_q + BW'(1);
         end else begin
            cyc_q <= cyc_q + CW'(1);
         end

         if (state_q == LOAD) begin
            shift_q <= fifo_data;
            par_q   <= (^fifo_data) ^ (PARITY_ODD != 0);
         end else if (state_q == DATA && bit_tick) begin
            shift_q <= shift_q >> 1;
         end
      end
   end

   always_comb begin
      tx        = 1'b1;
      fifo_r_en = 1'b0;
      busy      = (state_q != IDLE);
      tx_done   = 1'b0;
      case (state_q)
         FETCH:  fifo_r_en = 1'b1;
         START:  tx = 1'b0;
         DATA:   tx = shift_q[0];
         PARITY: tx = par_q;
         STOP:   tx_done = bit_tick && (bit_q == STOP_LAST);
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain, even parity, odd parity with two
// stop bits) fed by small FIFO models; per-instance monitors check every frame cycle.
module tb_fifo_uart_tx;

   typedef struct packed {
      logic [7:0] w;
      logic       p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] en_v = '0;
   logic [2:0] empty_v;
   logic [2:0] ren_v, tx_v, busy_v, done_v;
   logic [7:0] data_v [3];

   logic [7:0] mem [3][16];
   int         wr [3];
   int         rd [3];
   logic [2:0] ren_prev = '0;
   exp_t       exp_q [3][$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .enable(en_v[0]), .fifo_empty(empty_v[0]), .fifo_data(data_v[0]),
      .fifo_r_en(ren_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .enable(en_v[1]), .fifo_empty(empty_v[1]), .fifo_data(data_v[1]),
      .fifo_r_en(ren_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
      .clk(clk), .rst(rst), .enable(en_v[2]), .fifo_empty(empty_v[2]), .fifo_data(data_v[2]),
      .fifo_r_en(ren_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

   function automatic int pe(input int idx);
      return (idx == 0) ? 0 : 1;
   endfunction

   function automatic int sb(input int idx);
      return (idx == 2) ? 2 : 1;
   endfunction

   function automatic void check(input string name, input int act, input int req, input bit ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) empty_v[i] = (rd[i] == wr[i]);
   end

   // FIFO models: data_out valid the cycle after the read strobe.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ren_v[i]) begin
            check("ren_while_empty", rd[i], wr[i], rd[i] != wr[i]);
            check("ren_single_pulse", int'(ren_prev[i]), 0, ren_prev[i] == 1'b0);
            if (rd[i] != wr[i]) begin
               data_v[i] <= mem[i][rd[i]];
               rd[i]     <= rd[i] + 1;
            end
         end
      end
      ren_prev <= ren_v;
   end

   task automatic push(input int idx, input logic [7:0] w, input logic p);
      mem[idx][wr[idx]] = w;
      wr[idx] = wr[idx] + 1;
      exp_q[idx].push_back('{w: w, p: p});
   endtask

   task automatic monitor(input int idx);
      int         gap, nb, k, bad;
      logic       aborted, exp_bit, par_act;
      logic [7:0] dat;
      exp_t       e;
      gap = 100;
      forever begin
         @(negedge clk);
         if (!rst) begin
            gap = 100;
            continue;
         end
         if (tx_v[idx]) begin
            gap++;
            continue;
         end
         check($sformatf("gap_u%0d", idx), gap, 3, gap >= 3);
         if (exp_q[idx].size() == 0) begin
            check($sformatf("unexpected_frame_u%0d", idx), 1, 0, 1'b0);
            e = '0;
         end else begin
            e = exp_q[idx].pop_front();
         end
         nb = 1 + 8 + pe(idx) + sb(idx);
         bad = 0; dat = '0; par_act = 1'b0; aborted = 1'b0;
         for (int n = 0; n < nb * 4; n++) begin
            if (n > 0) @(negedge clk);
            if (!rst) begin
               aborted = 1'b1;
               break;
            end
            k = n / 4;
            if (k == 0)                       exp_bit = 1'b0;
            else if (k <= 8)                  exp_bit = e.w[k-1];
            else if (pe(idx) == 1 && k == 9)  exp_bit = e.p;
            else                              exp_bit = 1'b1;
            if (tx_v[idx] !== exp_bit) bad++;
            if (busy_v[idx] !== 1'b1) bad++;
            if (done_v[idx] !== (n == nb * 4 - 1)) bad++;
            if (n % 4 == 2) begin
               if (k >= 1 && k <= 8) dat[k-1] = tx_v[idx];
               if (pe(idx) == 1 && k == 9) par_act = tx_v[idx];
            end
         end
         if (aborted) begin
            gap = 100;
            continue;
         end
         check($sformatf("frame_data_u%0d", idx), int'(dat), int'(e.w), dat == e.w);
         if (pe(idx) == 1)
            check($sformatf("parity_bit_u%0d", idx), int'(par_act), int'(e.p), par_act == e.p);
         check($sformatf("frame_shape_errs_u%0d", idx), bad, 0, bad == 0);
         @(negedge clk);
         if (rst)
            check($sformatf("busy_after_frame_u%0d", idx), int'(busy_v[idx]), 0, busy_v[idx] == 1'b0);
         gap = tx_v[idx] ? 1 : 0;
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);

   task automatic wait_idle(input int idx, input int max_cyc, input string name);
      int n = 0;
      while ((exp_q[idx].size() != 0 || busy_v[idx]) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, n, max_cyc, n < max_cyc);
   endtask

   initial begin
      int n, lows, rens;
      for (int i = 0; i < 3; i++) begin
         wr[i] = 0;
         rd[i] = 0;
         data_v[i] = '0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_tx", int'(tx_v[i]), 1, tx_v[i] == 1'b1);
         check("reset_busy", int'(busy_v[i]), 0, busy_v[i] == 1'b0);
         check("reset_ren", int'(ren_v[i]), 0, ren_v[i] == 1'b0);
         check("reset_done", int'(done_v[i]), 0, done_v[i] == 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);

      // Single byte A5
      push(0, 8'hA5, 1'b0);
      en_v[0] = 1'b1;
      wait_idle(0, 200, "t1_timeout");
      en_v[0] = 1'b0;
      check("t1_reads", rd[0], 1, rd[0] == 1);

      // Drain eight words back to back
      for (int v = 1; v <= 8; v++) push(0, 8'(v), 1'b0);
      en_v[0] = 1'b1;
      wait_idle(0, 600, "t2_timeout");
      repeat (10) @(negedge clk);
      check("t2_reads", rd[0], 9, rd[0] == 9);
      check("t2_idle_busy", int'(busy_v[0]), 0, busy_v[0] == 1'b0);
      en_v[0] = 1'b0;

      // Enable gating
      push(0, 8'h11, 1'b0);
      push(0, 8'h22, 1'b0);
      lows = 0; rens = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!tx_v[0]) lows++;
         if (ren_v[0]) rens++;
      end
      check("t4_gate_ren", rens, 0, rens == 0);
      check("t4_gate_tx_low", lows, 0, lows == 0);
      en_v[0] = 1'b1;
      n = 0;
      while (!busy_v[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_start_timeout", n, 20, n < 20);
      en_v[0] = 1'b0;
      n = 0;
      while (busy_v[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_finish_timeout", n, 100, n < 100);
      repeat (50) @(negedge clk);
      check("t4_reads_after_disable", rd[0], 10, rd[0] == 10);

      // Reset in DATA bit 3 of word 22; word 33 must follow intact
      push(0, 8'h33, 1'b0);
      en_v[0] = 1'b1;
      n = 0;
      while (tx_v[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_start_timeout", n, 20, n < 20);
      repeat (17) @(negedge clk);
      check("t5_pre_reset_busy", int'(busy_v[0]), 1, busy_v[0] == 1'b1);
      #1 rst = 1'b0;
      #1;
      check("t5_rst_tx", int'(tx_v[0]), 1, tx_v[0] == 1'b1);
      check("t5_rst_busy", int'(busy_v[0]), 0, busy_v[0] == 1'b0);
      check("t5_rst_ren", int'(ren_v[0]), 0, ren_v[0] == 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_idle(0, 200, "t5_timeout");
      en_v[0] = 1'b0;
      check("t5_reads", rd[0], 12, rd[0] == 12);

      // Parity and two stop bits
      push(1, 8'h07, 1'b1);
      push(2, 8'h07, 1'b0);
      push(2, 8'h00, 1'b1);
      en_v[2:1] = 2'b11;
      wait_idle(1, 300, "t3_even_timeout");
      wait_idle(2, 300, "t6_odd_stop2_timeout");
      en_v[2:1] = 2'b00;
      check("t3_reads_u1", rd[1], 1, rd[1] == 1);
      check("t6_reads_u2", rd[2], 2, rd[2] == 2);

      repeat (5) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("end_exp_empty", exp_q[i].size(), 0, exp_q[i].size() == 0);
         check("end_fifo_drained", rd[i], wr[i], rd[i] == wr[i]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the synchronous FIFO. It drains the FIFO one word at a time and serialises each word as an asynchronous UART frame: start bit, data bits LSB first, optional parity bit, stop bit(s). It sits directly downstream of the FIFO. Its read enable and data input connect to the FIFO's r_en and data_out, and it monitors the FIFO's empty flag.

Parameters:
WIDTH, 8, data bits per frame; must equal the FIFO width.
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (rst = 0 resets).
enable  input  1  permits starting a new frame; sampled in IDLE only.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  WIDTH  FIFO data_out; valid on the cycle after fifo_r_en is high.
fifo_r_en  output  1  FIFO read strobe; single-cycle pulse per word.
tx  output  1  serial line; idle high.
busy  output  1  high from FETCH through the end of the last stop bit.
tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (rst = 0, asynchronous), taking effect immediately without waiting for clk:
  - state = IDLE; tx = 1; fifo_r_en = 0; busy = 0; tx_done = 0.
  - Bit counter, cycle counter and shift register are cleared.
  - A frame in progress is abandoned; the FIFO word already popped is lost.
  - After rst returns high, operation resumes from IDLE on the next rising edge.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. Go to FETCH when enable = 1 and fifo_empty = 0; otherwise stay.
  - FETCH: fifo_r_en = 1 for exactly this one cycle. Always go to LOAD.
  - LOAD: capture fifo_data into the shift register, compute parity over the captured word, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift_reg[0]; shift right every CLKS_PER_BIT cycles. After WIDTH bits, go to PARITY if PARITY_EN = 1, else to STOP.
  - PARITY: tx = XOR of the data bits (inverted when PARITY_ODD = 1) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT cycles. tx_done pulses on the last cycle. Then go to IDLE.
- Cycle counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0 .. CLKS_PER_BIT-1; the terminal count advances the bit.
  - Reloads to 0 on every state change.
- Frame length in clk cycles: (1 + WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.
- Back-to-back frames: minimum gap between the end of the stop bit and the next start bit is 3 cycles (IDLE, FETCH, LOAD), with tx held high throughout.
- Read rules:
  - fifo_r_en is never asserted while fifo_empty = 1 in the same IDLE decision.
  - Exactly one pulse per frame; never asserted outside FETCH.
- enable deasserted mid-frame: the current frame completes normally; the block then waits in IDLE.
- fifo_empty changes are ignored outside IDLE.
- busy = 1 in every state except IDLE.
- Once a word is captured in LOAD, tx is unaffected by fifo_data changes for the rest of the frame.

Test Plan:
1. Single byte (CLKS_PER_BIT = 4, PARITY_EN = 0, STOP_BITS = 1): FIFO holds 8'hA5, enable = 1 -> exactly one fifo_r_en pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1; each bit 4 cycles; tx_done 40 cycles after START entry; busy low afterwards.
2. Drain full FIFO (DEPTH = 8, data 1..8): eight frames in order 1..8; eight fifo_r_en pulses total; 3-cycle high gap between frames; no fifo_r_en once fifo_empty = 1; block idles in IDLE.
3. Parity: PARITY_EN = 1, byte 8'h07 -> even-parity bit 1; with PARITY_ODD = 1 -> bit 0; frame length 44 cycles at CLKS_PER_BIT = 4.
4. enable gating: enable = 0 with FIFO non-empty -> no fifo_r_en and tx stays 1 for 100 cycles. Deassert enable mid-frame -> frame completes, then no further reads.
5. Reset mid-frame: assert rst = 0 during DATA bit 3 -> tx = 1, busy = 0, fifo_r_en = 0 immediately (before the next edge). After release, the next frame carries the next FIFO word intact.
6. STOP_BITS = 2: byte 8'h00 -> stop high for 8 cycles; tx_done only on the final stop cycle.
